// File: rtl/vslc_pkg.sv
// vslc_pkg
//   Constants and types shared between the VSLC core and its scan scheduler.
//   - VSLC_* defaults for task count, period width, EEPROM address width and
//     the vector table placement (base address, bytes per entry).
//   - vect_field_e: byte offsets of the fields inside one vector-table entry.
//   - sat_inc8: saturating 8-bit increment used by event counters.
package vslc_pkg;

  localparam int VSLC_NUM_TASKS   = 4;
  localparam int VSLC_PERIOD_W    = 8;
  localparam int VSLC_ADDR_W      = 10;
  localparam int VSLC_VECT_BASE   = 0;
  localparam int VSLC_VECT_STRIDE = 4;
  localparam int VSLC_TASK_ID_W   = $clog2(VSLC_NUM_TASKS);

  // Layout of one vector entry: program start address then end address,
  // each stored high byte first.
  typedef enum logic [1:0] {
    VE_START_H = 2'd0,
    VE_START_L = 2'd1,
    VE_END_H   = 2'd2,
    VE_END_L   = 2'd3
  } vect_field_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vslc_task_timer.sv
// vslc_task_timer
//   State for one periodic task: period, countdown, enable, pending activation
//   and sticky deadline-miss flag.
// Ports
//   scan_cycle_clk  in   scheduler clock, one edge per scan
//   rst_n           in   synchronous active-low reset
//   cfg_we          in   config write addressed to this task (already decoded)
//   cfg_period      in   new period (scans between activations minus 1)
//   cfg_en          in   new enable
//   dispatch        in   this task is being dispatched on this edge
//   due             out  enabled and countdown has reached zero
//   ready           out  eligible for dispatch this edge
//   missed          out  sticky deadline-miss flag
module vslc_task_timer
  import vslc_pkg::*;
#(
  parameter int PERIOD_W = VSLC_PERIOD_W
) (
  input  logic                scan_cycle_clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_en,
  input  logic                dispatch,
  output logic                due,
  output logic                ready,
  output logic                missed
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] countdown_q, countdown_d;
  logic                en_q, en_d;
  logic                pending_q, pending_d;
  logic                missed_q, missed_d;

  assign due    = en_q && (countdown_q == '0);
  // A task being reconfigured this edge is never offered to the dispatcher.
  assign ready  = en_q && (pending_q || due) && !cfg_we;
  assign missed = missed_q;

  always_comb begin
    period_d    = period_q;
    countdown_d = countdown_q;
    en_d        = en_q;
    pending_d   = pending_q;
    missed_d    = missed_q;
    if (cfg_we) begin
      // Reconfiguration restarts the task from a clean slate.
      period_d    = cfg_period;
      en_d        = cfg_en;
      countdown_d = cfg_period;
      pending_d   = 1'b0;
      missed_d    = 1'b0;
    end else if (en_q) begin
      if (due) begin
        countdown_d = period_q;
        pending_d   = 1'b1;
        // New activation while the previous one never ran: deadline missed.
        if (pending_q) missed_d = 1'b1;
      end else begin
        countdown_d = countdown_q - PERIOD_W'(1);
      end
      if (dispatch) pending_d = 1'b0;
    end
  end

  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) begin
      period_q    <= '0;
      countdown_q <= '0;
      en_q        <= 1'b0;
      pending_q   <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      period_q    <= period_d;
      countdown_q <= countdown_d;
      en_q        <= en_d;
      pending_q   <= pending_d;
      missed_q    <= missed_d;
    end
  end

endmodule

// File: rtl/vslc_scan_scheduler.sv
// vslc_scan_scheduler
//   Per-scan task scheduler. Each scan edge it picks the lowest-index ready
//   task and hands the core that task's vector-table address. Flags overruns
//   (core still busy) and per-task deadline misses.
// Ports
//   scan_cycle_clk  in   scheduler clock, one rising edge per scan
//   rst_n           in   synchronous active-low reset
//   cfg_we/cfg_task/cfg_period/cfg_en  in  task configuration write
//   busy            in   core still executing the previous program
//   task_valid      out  a task was dispatched this scan
//   task_id         out  dispatched task index
//   vect_addr       out  vector-table address of the dispatched task
//   overrun         out  busy was high at this edge, nothing dispatched
//   overrun_count   out  saturating count of overrun edges
//   missed          out  sticky per-task deadline-miss flags
module vslc_scan_scheduler
  import vslc_pkg::*;
#(
  parameter int NUM_TASKS   = VSLC_NUM_TASKS,
  parameter int PERIOD_W    = VSLC_PERIOD_W,
  parameter int ADDR_W      = VSLC_ADDR_W,
  parameter int VECT_BASE   = VSLC_VECT_BASE,
  parameter int VECT_STRIDE = VSLC_VECT_STRIDE
) (
  input  logic                         scan_cycle_clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_TASKS)-1:0] cfg_task,
  input  logic [PERIOD_W-1:0]          cfg_period,
  input  logic                         cfg_en,
  input  logic                         busy,
  output logic                         task_valid,
  output logic [$clog2(NUM_TASKS)-1:0] task_id,
  output logic [ADDR_W-1:0]            vect_addr,
  output logic                         overrun,
  output logic [7:0]                   overrun_count,
  output logic [NUM_TASKS-1:0]         missed
);

  localparam int TID_W = $clog2(NUM_TASKS);

  logic [NUM_TASKS-1:0] due_vec;
  logic [NUM_TASKS-1:0] ready_vec;
  logic [NUM_TASKS-1:0] dispatch_oh;

  // Out-of-range cfg_task matches no instance, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < NUM_TASKS; gi++) begin : g_task
      vslc_task_timer #(
        .PERIOD_W (PERIOD_W)
      ) u_timer (
        .scan_cycle_clk (scan_cycle_clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we && (cfg_task == TID_W'(gi))),
        .cfg_period     (cfg_period),
        .cfg_en         (cfg_en),
        .dispatch       (dispatch_oh[gi]),
        .due            (due_vec[gi]),
        .ready          (ready_vec[gi]),
        .missed         (missed[gi])
      );
    end
  endgenerate

  // Fixed-priority encoder: lowest index wins.
  logic             win_found;
  logic [TID_W-1:0] win_idx;
  logic [ADDR_W-1:0] win_addr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        win_found = 1'b1;
        win_idx   = TID_W'(i);
      end
    end
    win_addr = ADDR_W'(VECT_BASE + int'(win_idx) * VECT_STRIDE);
  end

  // Dispatch register
  logic              task_valid_q, task_valid_d;
  logic [TID_W-1:0]  task_id_q, task_id_d;
  logic [ADDR_W-1:0] vect_addr_q, vect_addr_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        overrun_count_q, overrun_count_d;

  always_comb begin
    dispatch_oh     = '0;
    task_valid_d    = 1'b0;
    task_id_d       = task_id_q;
    vect_addr_d     = vect_addr_q;
    overrun_d       = 1'b0;
    overrun_count_d = overrun_count_q;
    if (busy) begin
      // Core has not finished: skip this scan, pending work stays queued.
      overrun_d       = 1'b1;
      overrun_count_d = sat_inc8(overrun_count_q);
    end else if (win_found) begin
      dispatch_oh[win_idx] = 1'b1;
      task_valid_d         = 1'b1;
      task_id_d            = win_idx;
      vect_addr_d          = win_addr;
    end
  end

  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) begin
      task_valid_q    <= 1'b0;
      task_id_q       <= '0;
      vect_addr_q     <= ADDR_W'(VECT_BASE);
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      task_valid_q    <= task_valid_d;
      task_id_q       <= task_id_d;
      vect_addr_q     <= vect_addr_d;
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign task_valid    = task_valid_q;
  assign task_id       = task_id_q;
  assign vect_addr     = vect_addr_q;
  assign overrun       = overrun_q;
  assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_vslc_scan_scheduler.sv
// tb_vslc_scan_scheduler
//   Table of hand-derived vectors for the directed scenarios, a hand-written
//   saturation sequence, and a short random run against a behavioural model.
//   Every expected record goes through a scoreboard queue before comparison.
module tb_vslc_scan_scheduler;

  logic       scan_cycle_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_task = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_en = 1'b0;
  logic       busy = 1'b0;
  logic       task_valid;
  logic [1:0] task_id;
  logic [9:0] vect_addr;
  logic       overrun;
  logic [7:0] overrun_count;
  logic [3:0] missed;

  always #5 scan_cycle_clk = ~scan_cycle_clk;

  vslc_scan_scheduler dut (
    .scan_cycle_clk (scan_cycle_clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_task       (cfg_task),
    .cfg_period     (cfg_period),
    .cfg_en         (cfg_en),
    .busy           (busy),
    .task_valid     (task_valid),
    .task_id        (task_id),
    .vect_addr      (vect_addr),
    .overrun        (overrun),
    .overrun_count  (overrun_count),
    .missed         (missed)
  );

  typedef struct packed {
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_task;
    logic [7:0] cfg_period;
    logic       cfg_en;
    logic       busy;
  } in_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
    logic [9:0] addr;
    logic       ovr;
    logic [7:0] cnt;
    logic [3:0] missed;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s %s actual=%0d expected=%0d", tag, nm, act, expv);
    end
  endtask

  // Drive one scan worth of inputs, queue the expectation, compare after the edge.
  task automatic apply(input in_t in, input exp_t e, input string tag);
    exp_t x;
    rst_n      = in.rst_n;
    cfg_we     = in.cfg_we;
    cfg_task   = in.cfg_task;
    cfg_period = in.cfg_period;
    cfg_en     = in.cfg_en;
    busy       = in.busy;
    exp_q.push_back(e);
    @(posedge scan_cycle_clk);
    #1;
    x = exp_q.pop_front();
    $display("%s rst_n=%0d we=%0d busy=%0d -> valid=%0d id=%0d addr=%0d ovr=%0d cnt=%0d missed=%b",
             tag, in.rst_n, in.cfg_we, in.busy, task_valid, task_id, vect_addr, overrun,
             overrun_count, missed);
    chk(tag, "task_valid", int'(task_valid), int'(x.valid));
    chk(tag, "task_id", int'(task_id), int'(x.id));
    chk(tag, "vect_addr", int'(vect_addr), int'(x.addr));
    chk(tag, "overrun", int'(overrun), int'(x.ovr));
    chk(tag, "overrun_count", int'(overrun_count), int'(x.cnt));
    chk(tag, "missed", int'(missed), int'(x.missed));
  endtask

  // Row layout: r we task period en busy | valid id addr ovr cnt missed
  task automatic add(input logic r, input logic we, input logic [1:0] t, input logic [7:0] p,
                     input logic en, input logic b, input logic v, input logic [1:0] id,
                     input logic [9:0] a, input logic o, input logic [7:0] c,
                     input logic [3:0] m);
    vec_t row;
    row.in  = '{rst_n: r, cfg_we: we, cfg_task: t, cfg_period: p, cfg_en: en, busy: b};
    row.exp = '{valid: v, id: id, addr: a, ovr: o, cnt: c, missed: m};
    vecs.push_back(row);
  endtask

  // Behavioural reference for the random run.
  logic       m_en[4];
  logic [7:0] m_per[4];
  logic [7:0] m_cd[4];
  logic       m_pend[4];
  logic       m_miss[4];
  exp_t       m_out;

  task automatic model_step(input in_t in, output exp_t e);
    logic due[4];
    logic rdy[4];
    int   win;
    if (!in.rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_en[i] = 1'b0; m_per[i] = '0; m_cd[i] = '0; m_pend[i] = 1'b0; m_miss[i] = 1'b0;
      end
      m_out = '0;
    end else begin
      win = -1;
      for (int i = 0; i < 4; i++) begin
        due[i] = m_en[i] && (m_cd[i] == 8'd0);
        rdy[i] = m_en[i] && (m_pend[i] || due[i]) && !(in.cfg_we && in.cfg_task == 2'(i));
      end
      if (!in.busy)
        for (int i = 3; i >= 0; i--) if (rdy[i]) win = i;
      for (int i = 0; i < 4; i++) begin
        if (in.cfg_we && in.cfg_task == 2'(i)) begin
          m_per[i] = in.cfg_period; m_cd[i] = in.cfg_period; m_en[i] = in.cfg_en;
          m_pend[i] = 1'b0; m_miss[i] = 1'b0;
        end else if (m_en[i]) begin
          if (due[i]) begin
            if (m_pend[i]) m_miss[i] = 1'b1;
            m_pend[i] = 1'b1;
            m_cd[i] = m_per[i];
          end else begin
            m_cd[i] = m_cd[i] - 8'd1;
          end
          if (win == i) m_pend[i] = 1'b0;
        end
      end
      if (in.busy) begin
        m_out.ovr   = 1'b1;
        m_out.valid = 1'b0;
        if (m_out.cnt != 8'd255) m_out.cnt = m_out.cnt + 8'd1;
      end else begin
        m_out.ovr = 1'b0;
        if (win >= 0) begin
          m_out.valid = 1'b1;
          m_out.id    = 2'(win);
          m_out.addr  = 10'(win * 4);
        end else begin
          m_out.valid = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) m_out.missed[i] = m_miss[i];
    end
    e = m_out;
  endtask

  initial begin
    in_t  in;
    exp_t e;

    // 1: task0 every scan
    add(0,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,1,0,0,1,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0000);
    // 2: task0 and task1 both period 1, staggered by one scan -> clean alternation
    add(0,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,1,0,1,1,0, 0,0,0,0,0,4'b0000);
    add(1,1,1,1,1,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,1,4,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,1,4,0,0,4'b0000);
    // 3: both every scan -> task1 starves and misses
    add(0,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,1,0,0,1,0, 0,0,0,0,0,4'b0000);
    add(1,1,1,0,1,0, 1,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0010);
    add(1,0,0,0,0,0, 1,0,0,0,0,4'b0010);
    // 4: three busy scans with task0 due, then dispatch
    add(0,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,1,0,0,1,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,1, 0,0,0,1,1,4'b0000);
    add(1,0,0,0,0,1, 0,0,0,1,2,4'b0001);
    add(1,0,0,0,0,1, 0,0,0,1,3,4'b0001);
    add(1,0,0,0,0,0, 1,0,0,0,3,4'b0001);
    // 6: rewrite task2 on its due scan, busy hold of id/addr, mid-run reset
    add(0,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,1,2,2,1,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,2,8,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,2,8,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,2,8,0,0,4'b0000);
    add(1,1,2,3,1,0, 0,2,8,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,2,8,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,2,8,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,2,8,0,0,4'b0000);
    add(1,0,0,0,0,0, 1,2,8,0,0,4'b0000);
    add(1,0,0,0,0,1, 0,2,8,1,1,4'b0000);
    add(0,0,0,0,0,0, 0,0,0,0,0,4'b0000);
    add(1,0,0,0,0,0, 0,0,0,0,0,4'b0000);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].in, vecs[i].exp, $sformatf("tbl%0d", i));

    // 5: overrun counter saturates at 255 over 300 busy scans
    in = '{rst_n: 1'b0, cfg_we: 1'b0, cfg_task: 2'd0, cfg_period: 8'd0, cfg_en: 1'b0, busy: 1'b0};
    apply(in, exp_t'(0), "sat_rst");
    in.rst_n = 1'b1;
    in.busy  = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      e       = '0;
      e.ovr   = 1'b1;
      e.cnt   = (k > 255) ? 8'd255 : 8'(k);
      apply(in, e, $sformatf("sat%0d", k));
    end
    in.busy = 1'b0;
    e       = '0;
    e.cnt   = 8'd255;
    apply(in, e, "sat_end");

    // Random run against the model
    in = '{rst_n: 1'b0, cfg_we: 1'b0, cfg_task: 2'd0, cfg_period: 8'd0, cfg_en: 1'b0, busy: 1'b0};
    model_step(in, e);
    apply(in, e, "rnd_rst");
    for (int k = 0; k < 250; k++) begin
      in.rst_n      = ($urandom_range(0, 99) != 0);
      in.cfg_we     = ($urandom_range(0, 5) == 0);
      in.cfg_task   = 2'($urandom_range(0, 3));
      in.cfg_period = 8'($urandom_range(0, 5));
      in.cfg_en     = ($urandom_range(0, 3) != 0);
      in.busy       = ($urandom_range(0, 4) == 0);
      model_step(in, e);
      apply(in, e, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
